mbscore_intc: RTL and testbench

//  Interrupt controller for MBScore. It is the initiator side of the register file's

---
 rtl/mbscore_intc_pkg.sv | 23 ++
 rtl/mbscore_intc_prio.sv | 25 ++
 rtl/mbscore_intc.sv | 121 ++++++++++++
 tb/tb_mbscore_intc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbscore_intc_pkg.sv
// Shared constants for the MBScore interrupt controller: FSM encodings,
// config register map and the default vector base.
package mbscore_intc_pkg;

  typedef enum logic [1:0] {
    INTC_ST_IDLE = 2'd0,
    INTC_ST_ARB  = 2'd1,
    INTC_ST_TAKE = 2'd2,
    INTC_ST_SERV = 2'd3
  } intc_state_e;

  localparam logic [1:0] INTC_REG_MASK  = 2'd0;
  localparam logic [1:0] INTC_REG_PEND  = 2'd1;
  localparam logic [1:0] INTC_REG_CAUSE = 2'd2;
  localparam logic [1:0] INTC_REG_STAT  = 2'd3;

  localparam logic [31:0] INTC_VEC_BASE = 32'h0000_0080;

  function automatic int intc_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mbscore_intc_prio.sv
// Fixed-priority encoder: lowest set request index wins.
module mbscore_intc_prio
  import mbscore_intc_pkg::*;
#(
  parameter int N    = 8,
  parameter int ID_W = intc_id_width(N)
) (
  input  logic [N-1:0]    i_req,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  // Scan from the top down so the lowest index is the last (winning) assignment.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/mbscore_intc.sv
// MBScore interrupt controller: IRQ edge capture, mask/priority, boundary-aligned
// entry into the handler via the RF setINTR pulse and a fetch redirect.
module mbscore_intc
  import mbscore_intc_pkg::*;
#(
  parameter int                    N_IRQ      = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] VEC_BASE   = DATA_WIDTH'(INTC_VEC_BASE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IRQ-1:0]      irq_in,
  input  logic                  int_en_n,
  input  logic                  boundary,
  input  logic [DATA_WIDTH-1:0] pc_in,
  output logic                  set_intr,
  output logic [DATA_WIDTH-1:0] epc_out,
  output logic                  vec_we,
  output logic [DATA_WIDTH-1:0] vec_pc,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic [DATA_WIDTH-1:0] cfg_rdata
);

  localparam int ID_W = intc_id_width(N_IRQ);

  intc_state_e           r_state, w_state_next;
  logic [N_IRQ-1:0]      r_sync1, r_sync2, r_sync_d;
  logic [N_IRQ-1:0]      r_pend, r_mask;
  logic [ID_W-1:0]       r_cause;
  logic [DATA_WIDTH-1:0] r_epc;
  logic                  r_seen_dis;

  logic [N_IRQ-1:0] w_edge, w_elig, w_cause_oh, w_w1c, w_take_clr, w_pend_next;
  logic             w_win_valid, w_cause_live, w_take_entry;
  logic [ID_W-1:0]  w_win_id;
  logic             w_unused_wdata;

  assign w_edge       = r_sync2 & ~r_sync_d;
  assign w_elig       = r_pend & r_mask;
  assign w_cause_oh   = N_IRQ'(1) << r_cause;
  assign w_cause_live = |(w_elig & w_cause_oh);
  assign w_take_entry = (r_state == INTC_ST_ARB) && w_cause_live && boundary;

  // A fresh edge always beats a software or auto clear on the same bit.
  assign w_w1c       = (cfg_we && cfg_addr == INTC_REG_PEND) ? cfg_wdata[N_IRQ-1:0] : '0;
  assign w_take_clr  = w_take_entry ? w_cause_oh : '0;
  assign w_pend_next = (r_pend & ~(w_w1c | w_take_clr)) | w_edge;

  assign w_unused_wdata = ^cfg_wdata;

  mbscore_intc_prio #(.N(N_IRQ), .ID_W(ID_W)) u_prio (
    .i_req   (w_elig),
    .o_valid (w_win_valid),
    .o_id    (w_win_id)
  );

  always_comb begin
    w_state_next = r_state;
    set_intr     = 1'b0;
    vec_we       = 1'b0;
    epc_out      = r_epc;
    vec_pc       = VEC_BASE + (DATA_WIDTH'(r_cause) << 3);
    case (r_state)
      INTC_ST_IDLE: if (w_win_valid && !int_en_n) w_state_next = INTC_ST_ARB;
      INTC_ST_ARB: begin
        if (!w_cause_live)  w_state_next = INTC_ST_IDLE;
        else if (boundary)  w_state_next = INTC_ST_TAKE;
      end
      INTC_ST_TAKE: begin
        set_intr     = 1'b1;
        vec_we       = 1'b1;
        w_state_next = INTC_ST_SERV;
      end
      INTC_ST_SERV: if (r_seen_dis && !int_en_n) w_state_next = INTC_ST_IDLE;
      default:      w_state_next = INTC_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= INTC_ST_IDLE;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sync_d   <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_cause    <= '0;
      r_epc      <= '0;
      r_seen_dis <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_sync1  <= irq_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_pend   <= w_pend_next;
      if (cfg_we && cfg_addr == INTC_REG_MASK) r_mask <= cfg_wdata[N_IRQ-1:0];
      if (r_state == INTC_ST_IDLE && w_state_next == INTC_ST_ARB) r_cause <= w_win_id;
      if (w_take_entry) r_epc <= pc_in;
      // The handler must disable then re-enable; remember the disable once seen.
      if (r_state == INTC_ST_SERV) begin
        if (int_en_n) r_seen_dis <= 1'b1;
      end else begin
        r_seen_dis <= 1'b0;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      INTC_REG_MASK:  cfg_rdata = DATA_WIDTH'(r_mask);
      INTC_REG_PEND:  cfg_rdata = DATA_WIDTH'(r_pend);
      INTC_REG_CAUSE: cfg_rdata = DATA_WIDTH'(r_cause);
      INTC_REG_STAT:  cfg_rdata = DATA_WIDTH'(r_state);
      default:        cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mbscore_intc.sv
// Scoreboard bench for mbscore_intc: stimulus queues expected pulses and
// register reads; a negedge monitor pops and compares them.
module tb_mbscore_intc;
  import mbscore_intc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_in;
  logic        int_en_n, boundary;
  logic [31:0] pc_in;
  logic        set_intr, vec_we;
  logic [31:0] epc_out, vec_pc;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        rd_valid;

  typedef struct {
    logic [31:0] epc;
    logic [31:0] vec;
  } pulse_t;

  typedef struct {
    string       name;
    logic [31:0] val;
    bit          is_out;
  } rd_t;

  pulse_t pulse_q[$];
  rd_t    rd_q[$];
  int     errors = 0;
  int     checks = 0;

  always #5 clk = ~clk;

  mbscore_intc #(.N_IRQ(8), .DATA_WIDTH(32), .VEC_BASE(32'h0000_0080)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .int_en_n  (int_en_n),
    .boundary  (boundary),
    .pc_in     (pc_in),
    .set_intr  (set_intr),
    .epc_out   (epc_out),
    .vec_we    (vec_we),
    .vec_pc    (vec_pc),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin : monitor
    pulse_t pe;
    rd_t    re;
    forever begin
      @(negedge clk);
      if (set_intr || vec_we) begin
        checks++;
        if (pulse_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: set_intr=%0b vec_we=%0b vec_pc=%h, required no pulse",
                   set_intr, vec_we, vec_pc);
        end else begin
          pe = pulse_q.pop_front();
          if (!(set_intr && vec_we) || epc_out !== pe.epc || vec_pc !== pe.vec) begin
            errors++;
            $display("FAIL pulse: set_intr=%0b vec_we=%0b epc=%h vec_pc=%h, required 1 1 epc=%h vec_pc=%h",
                     set_intr, vec_we, epc_out, vec_pc, pe.epc, pe.vec);
          end else begin
            $display("pulse: epc=%h vec_pc=%h ok", epc_out, vec_pc);
          end
        end
      end
      if (rd_valid) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL read_queue: read strobe with no expectation queued");
        end else begin
          re = rd_q.pop_front();
          if (re.is_out) begin
            if (set_intr !== 1'b0 || vec_we !== 1'b0 || epc_out !== 32'h0 || vec_pc !== re.val) begin
              errors++;
              $display("FAIL %s: set_intr=%0b vec_we=%0b epc=%h vec_pc=%h, required 0 0 epc=0 vec_pc=%h",
                       re.name, set_intr, vec_we, epc_out, vec_pc, re.val);
            end else begin
              $display("%s: outputs at reset values ok", re.name);
            end
          end else if (cfg_rdata !== re.val) begin
            errors++;
            $display("FAIL %s: got %h, required %h", re.name, cfg_rdata, re.val);
          end else begin
            $display("%s: %h ok", re.name, cfg_rdata);
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic rd_check(input string nm, input logic [1:0] a, input logic [31:0] v);
    rd_t r;
    r.name = nm; r.val = v; r.is_out = 1'b0;
    rd_q.push_back(r);
    cfg_addr = a;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic out_check(input string nm, input logic [31:0] vec);
    rd_t r;
    r.name = nm; r.val = vec; r.is_out = 1'b1;
    rd_q.push_back(r);
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic expect_pulse(input logic [31:0] epc, input logic [31:0] vec);
    pulse_t p;
    p.epc = epc; p.vec = vec;
    pulse_q.push_back(p);
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    irq_in = bits;
    tick();
    irq_in = 8'h00;
  endtask

  task automatic wait_pulses(input int target, input int bound);
    int n = 0;
    while (pulse_q.size() > target && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (pulse_q.size() > target) begin
      errors++;
      $display("FAIL pulse_timeout: outstanding=%0d, required %0d within %0d clks",
               pulse_q.size(), target, bound);
    end
  endtask

  task automatic release_serv();
    int_en_n = 1'b1;
    tick();
    int_en_n = 1'b0;
    tick(2);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1; irq_in = 8'h00; int_en_n = 1'b0; boundary = 1'b0; pc_in = 32'h0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'h0; rd_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick();

    // Reset state
    out_check("reset_outputs", 32'h80);
    rd_check("reset_mask", INTC_REG_MASK, 32'h0);
    rd_check("reset_pend", INTC_REG_PEND, 32'h0);
    rd_check("reset_status", INTC_REG_STAT, 32'h0);

    // 1: single IRQ 0
    cfg_write(INTC_REG_MASK, 32'h01);
    rd_check("t1_mask", INTC_REG_MASK, 32'h01);
    boundary = 1'b1;
    pc_in    = 32'h100;
    expect_pulse(32'h100, 32'h80);
    pulse_irq(8'h01);
    wait_pulses(0, 10);
    rd_check("t1_cause", INTC_REG_CAUSE, 32'h0);
    rd_check("t1_pend", INTC_REG_PEND, 32'h0);
    rd_check("t1_status_serv", INTC_REG_STAT, 32'h3);
    release_serv();
    rd_check("t1_status_idle", INTC_REG_STAT, 32'h0);

    // 2: simultaneous IRQ 5 and 2, priority then deferred take
    cfg_write(INTC_REG_MASK, 32'hFFFF_FFFF);
    rd_check("t2_mask_upper_zero", INTC_REG_MASK, 32'hFF);
    pc_in = 32'h200;
    expect_pulse(32'h200, 32'h90);
    expect_pulse(32'h300, 32'hA8);
    pulse_irq(8'h24);
    wait_pulses(1, 10);
    pc_in = 32'h300;
    rd_check("t2_pend_after_first", INTC_REG_PEND, 32'h20);
    rd_check("t2_cause_first", INTC_REG_CAUSE, 32'h2);
    release_serv();
    wait_pulses(0, 10);
    rd_check("t2_cause_second", INTC_REG_CAUSE, 32'h5);
    rd_check("t2_pend_final", INTC_REG_PEND, 32'h0);
    release_serv();

    // 3: disabled globally, then re-enabled
    cfg_write(INTC_REG_MASK, 32'h08);
    int_en_n = 1'b1;
    pc_in    = 32'h400;
    pulse_irq(8'h08);
    tick(5);
    rd_check("t3_pend_held", INTC_REG_PEND, 32'h08);
    rd_check("t3_status_idle", INTC_REG_STAT, 32'h0);
    expect_pulse(32'h400, 32'h98);
    int_en_n = 1'b0;
    wait_pulses(0, 3);
    release_serv();

    // 4: W1C of winner while waiting for a boundary
    cfg_write(INTC_REG_MASK, 32'h01);
    boundary = 1'b0;
    pulse_irq(8'h01);
    tick(4);
    rd_check("t4_status_arb", INTC_REG_STAT, 32'h1);
    cfg_write(INTC_REG_PEND, 32'h01);
    tick(2);
    rd_check("t4_status_back_idle", INTC_REG_STAT, 32'h0);
    boundary = 1'b1;
    tick(4);
    rd_check("t4_pend_cleared", INTC_REG_PEND, 32'h0);

    // 5: reset while in SERV
    cfg_write(INTC_REG_MASK, 32'h02);
    pc_in = 32'h500;
    expect_pulse(32'h500, 32'h88);
    pulse_irq(8'h02);
    wait_pulses(0, 10);
    pulse_irq(8'h02);
    tick(4);
    rd_check("t5_pend_before_rst", INTC_REG_PEND, 32'h02);
    rd_check("t5_status_serv", INTC_REG_STAT, 32'h3);
    rst = 1'b1;
    out_check("t5_outputs_in_rst", 32'h80);
    rd_check("t5_mask_rst", INTC_REG_MASK, 32'h0);
    rd_check("t5_pend_rst", INTC_REG_PEND, 32'h0);
    rd_check("t5_cause_rst", INTC_REG_CAUSE, 32'h0);
    rd_check("t5_status_rst", INTC_REG_STAT, 32'h0);
    rst = 1'b0;
    tick();
    cfg_write(INTC_REG_MASK, 32'h02);
    tick(6);
    rd_check("t5_status_after_rst", INTC_REG_STAT, 32'h0);

    // 6: W1C colliding with a new edge on bit 4
    cfg_write(INTC_REG_MASK, 32'h00);
    pulse_irq(8'h10);
    tick(4);
    rd_check("t6_pend_set", INTC_REG_PEND, 32'h10);
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    tick();
    cfg_write(INTC_REG_PEND, 32'h10);
    rd_check("t6_set_wins", INTC_REG_PEND, 32'h10);
    cfg_write(INTC_REG_PEND, 32'h10);
    rd_check("t6_w1c_alone", INTC_REG_PEND, 32'h0);

    tick(2);
    checks++;
    if (pulse_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: pulses=%0d reads=%0d outstanding, required 0 0",
               pulse_q.size(), rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
